// File: rtl/serial_xs3_bcd_codec.sv
// Bit-serial LSB-first excess-3 <-> BCD converter with framing,
// restart/abort handling and per-digit code-validity checking.
module serial_xs3_bcd_codec #(
  parameter int DIGITS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_mode,
  input  logic i_in_valid,
  input  logic i_in_bit,
  input  logic i_in_first,
  output logic o_out_valid,
  output logic o_out_bit,
  output logic o_out_last,
  output logic o_digit_err,
  output logic o_frame_err,
  output logic o_abort
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic          r_mode;
  logic          r_carry;
  logic [1:0]    r_bit_cnt;
  logic [DW-1:0] r_dig_cnt;
  logic [2:0]    r_shift;
  logic          r_sticky;
  logic          r_out_valid;
  logic          r_out_bit;
  logic          r_out_last;
  logic          r_digit_err;
  logic          r_frame_err;
  logic          r_abort;

  logic          w_start;
  logic          w_accept;
  logic          w_mode;
  logic [1:0]    w_bit;
  logic [DW-1:0] w_dig;
  logic          w_c;
  logic [3:0]    w_k_vec;
  logic          w_k;
  logic          w_sum;
  logic          w_cnext;
  logic [3:0]    w_digit;
  logic          w_range_err;
  logic          w_err;
  logic          w_last;
  logic          w_sticky;

  // A frame start (first bit) resets the frame context in the same cycle.
  assign w_start  = i_in_valid & i_in_first;
  assign w_accept = i_in_valid & (i_in_first | (r_state == RUN));
  assign w_mode   = w_start ? i_mode : r_mode;
  assign w_bit    = w_start ? 2'd0 : r_bit_cnt;
  assign w_dig    = w_start ? '0 : r_dig_cnt;
  assign w_c      = (w_bit == 2'd0) ? 1'b0 : r_carry;
  assign w_k_vec  = w_mode ? 4'b0011 : 4'b1101;
  assign w_k      = w_k_vec[w_bit];
  assign w_sum    = i_in_bit ^ w_k ^ w_c;
  assign w_cnext  = (i_in_bit & w_k) | (i_in_bit & w_c) | (w_k & w_c);

  assign w_digit  = {i_in_bit, r_shift};
  assign w_range_err = w_mode ? (w_digit > 4'd9)
                              : ((w_digit < 4'd3) || (w_digit > 4'd12));
  assign w_err    = (w_bit == 2'd3) & w_range_err;
  assign w_last   = (w_bit == 2'd3) && (w_dig == DW'(DIGITS - 1));
  assign w_sticky = (w_start ? 1'b0 : r_sticky) | w_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= 1'b0;
      r_carry     <= 1'b0;
      r_bit_cnt   <= 2'd0;
      r_dig_cnt   <= '0;
      r_shift     <= 3'd0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_bit   <= 1'b0;
      r_out_last  <= 1'b0;
      r_digit_err <= 1'b0;
      r_frame_err <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      r_out_bit   <= w_accept & w_sum;
      r_out_last  <= w_accept & w_last;
      r_digit_err <= w_accept & w_err;
      r_frame_err <= w_accept & w_last & w_sticky;
      r_abort     <= w_start & (r_state == RUN);
      if (w_accept) begin
        r_mode    <= w_mode;
        r_carry   <= w_cnext;
        r_shift   <= {i_in_bit, r_shift[2:1]};
        r_sticky  <= w_sticky;
        r_bit_cnt <= w_bit + 2'd1;
        if (w_bit == 2'd3)
          r_dig_cnt <= w_last ? '0 : w_dig + 1'b1;
        else
          r_dig_cnt <= w_dig;
        r_state <= w_last ? IDLE : RUN;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_bit   = r_out_bit;
  assign o_out_last  = r_out_last;
  assign o_digit_err = r_digit_err;
  assign o_frame_err = r_frame_err;
  assign o_abort     = r_abort;

endmodule

// File: tb/tb_serial_xs3_bcd_codec.sv
// Directed bench for serial_xs3_bcd_codec: one-digit and two-digit
// instances share the stimulus; each test checks the relevant one.
module tb_serial_xs3_bcd_codec;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic i_mode = 1'b0;
  logic i_in_valid = 1'b0;
  logic i_in_bit = 1'b0;
  logic i_in_first = 1'b0;

  logic ov0, ob0, ol0, de0, fe0, ab0;
  logic ov1, ob1, ol1, de1, fe1, ab1;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  serial_xs3_bcd_codec #(.DIGITS(1)) u_d1 (
    .clock      (clock),
    .reset      (reset),
    .i_mode     (i_mode),
    .i_in_valid (i_in_valid),
    .i_in_bit   (i_in_bit),
    .i_in_first (i_in_first),
    .o_out_valid(ov0),
    .o_out_bit  (ob0),
    .o_out_last (ol0),
    .o_digit_err(de0),
    .o_frame_err(fe0),
    .o_abort    (ab0)
  );

  serial_xs3_bcd_codec #(.DIGITS(2)) u_d2 (
    .clock      (clock),
    .reset      (reset),
    .i_mode     (i_mode),
    .i_in_valid (i_in_valid),
    .i_in_bit   (i_in_bit),
    .i_in_first (i_in_first),
    .o_out_valid(ov1),
    .o_out_bit  (ob1),
    .o_out_last (ol1),
    .o_digit_err(de1),
    .o_frame_err(fe1),
    .o_abort    (ab1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b,
                       input logic f, input logic m);
    i_in_valid = v;
    i_in_bit   = b;
    i_in_first = f;
    i_mode     = m;
    @(posedge clock);
    #1;
    i_in_valid = 1'b0;
    i_in_first = 1'b0;
  endtask

  task automatic nib(input int u, input logic [3:0] d,
                     input logic first, input logic m,
                     input int gap,
                     output logic [3:0] q, output logic [3:0] vv,
                     output logic [3:0] ll, output logic [3:0] ee,
                     output logic [3:0] ff, output logic [3:0] aa,
                     output int gv);
    gv = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, d[i], first && (i == 0), m);
      q[i]  = u ? ob1 : ob0;
      vv[i] = u ? ov1 : ov0;
      ll[i] = u ? ol1 : ol0;
      ee[i] = u ? de1 : de0;
      ff[i] = u ? fe1 : fe0;
      aa[i] = u ? ab1 : ab0;
      for (int g = 0; g < gap; g++) begin
        drive(1'b0, 1'b0, 1'b0, m);
        if (u ? ov1 : ov0) gv++;
      end
    end
  endtask

  logic [3:0] q, vv, ll, ee, ff, aa;
  int gv;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {ov1, ov0}, 2'b00);
    chk("rst_flags", {ol0, de0, fe0, ab0, ol1, de1, fe1, ab1, ob0, ob1}, 10'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    nib(0, 4'd8, 1'b1, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t1_data", q, 4'd5);
    chk("t1_valid", vv, 4'hf);
    chk("t1_last", ll, 4'b1000);
    chk("t1_derr", ee, 4'd0);

    nib(0, 4'd9, 1'b1, 1'b1, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t2_data9", q, 4'd12);
    chk("t2_err9", {ee, ff}, 8'h00);
    nib(0, 4'd10, 1'b1, 1'b1, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t2_data10", q, 4'd13);
    chk("t2_derr10", ee, 4'b1000);
    chk("t2_ferr10", ff, 4'b1000);

    nib(1, 4'd3, 1'b1, 1'b0, 2, q, vv, ll, ee, ff, aa, gv);
    chk("t3_d0", q, 4'd0);
    chk("t3_v0", vv, 4'hf);
    chk("t3_gap0", gv, 0);
    chk("t3_last0", ll, 4'd0);
    nib(1, 4'd12, 1'b0, 1'b0, 2, q, vv, ll, ee, ff, aa, gv);
    chk("t3_d1", q, 4'd9);
    chk("t3_gap1", gv, 0);
    chk("t3_last1", ll, 4'b1000);
    chk("t3_err1", {ee, ff}, 8'h00);

    nib(1, 4'd1, 1'b1, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t4_d0", q, 4'd14);
    chk("t4_derr0", ee, 4'b1000);
    chk("t4_ferr0", {ll, ff}, 8'h00);
    nib(1, 4'd7, 1'b0, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t4_d1", q, 4'd4);
    chk("t4_derr1", ee, 4'd0);
    chk("t4_ferr1", ff, 4'b1000);

    nib(1, 4'd5, 1'b1, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t5_old0", q, 4'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_bit4", {ov1, ol1, ab1}, 3'b100);
    nib(1, 4'd2, 1'b1, 1'b1, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t5_abort", aa, 4'b0001);
    chk("t5_new0", q, 4'd5);
    chk("t5_nolast", ll, 4'd0);
    nib(1, 4'd4, 1'b0, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t5_new1", q, 4'd7);
    chk("t5_last", ll, 4'b1000);
    chk("t5_noab", aa, 4'd0);

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_drop", ov1, 1'b0);
    end

    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_rst", {ov1, ob1, ol1, de1, fe1, ab1}, 6'd0);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_postrst", ov1, 1'b0);
    nib(1, 4'd8, 1'b1, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t6_d0", q, 4'd5);
    chk("t6_ab0", aa, 4'd0);
    nib(1, 4'd12, 1'b0, 1'b0, 0, q, vv, ll, ee, ff, aa, gv);
    chk("t6_d1", q, 4'd9);
    chk("t6_last", ll, 4'b1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
